serial_add_sub: RTL and testbench
=================================

Name: serial_add_sub

Overview:
- Parametrised bit-serial adder/subtractor. One full-adder cell and a carry flip-flop process one bit per clock.
- Successor to the combinational ripple adders. It trades latency for area, and adds subtract mode, a signed-overflow flag and a start/done handshake.
- Sits in the datapath wherever an N-bit add/sub is needed and WIDTH-cycle latency is acceptable.

Parameters:
- WIDTH, 4, operand/result width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- Sub  input  1  0 = add, 1 = subtract; sampled with start.
- A  input  WIDTH  operand A; sampled with start.
- B  input  WIDTH  operand B; sampled with start.
- Cin  input  1  carry-in, add mode only; sampled with start; ignored when Sub=1.
- busy  output  1  high while bits are being processed (RUN).
- done  output  1  one-cycle pulse; Out/Cout/Ovf valid from this cycle on.
- Out  output  WIDTH  result, held until the next completion.
- Cout  output  1  carry out of MSB; in subtract mode 1 = no borrow.
- Ovf  output  1  two's-complement overflow = carry into MSB XOR carry out of MSB.

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE.
  - busy, done, Out, Cout and Ovf all go to 0.
  - Internal shift registers, bit counter and carry FF are cleared.
  - Reset mid-RUN aborts the operation: no done, and Out is not updated.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at a clock edge E0 captures the operands: opA<=A, opB<=Sub ? ~B : B, carry<=Sub ? 1 : Cin, cnt<=0.
  - State goes to RUN; busy=1 after E0.
  - With start=0, stay in IDLE.
- RUN, at each edge Ek (k=1..WIDTH):
  - sum bit = opA[0]^opB[0]^carry.
  - Shift sum into the MSB of the result shift register; shift opA and opB right by one.
  - carry <= majority(opA[0], opB[0], carry); cnt increments.
  - At the edge where cnt=WIDTH-1 is processed (edge E_WIDTH):
    - Out <= full result.
    - Cout <= final carry.
    - Ovf <= carry-into-MSB ^ final carry.
    - State goes to DONE.
- DONE:
  - done=1 and busy=0 for exactly one cycle.
  - The next edge returns to IDLE.
- Latency and throughput:
  - done rises exactly WIDTH clock edges after the start edge.
  - One operation per WIDTH+2 cycles.
- start handling:
  - start in RUN or DONE is ignored (not queued).
  - A, B, Sub and Cin may change freely after E0 without effect.
- Out/Cout/Ovf change only on the completion edge or on reset. They stay stable through IDLE, RUN and DONE of the next operation until that operation completes.
- Width rules:
  - Result is modulo 2^WIDTH; the carry beyond the MSB goes only to Cout.
  - Subtract is A + ~B + 1.

Test Plan:
- Reset and hold:
  - Assert rst mid-RUN.
  - Required: busy/done/Out/Cout/Ovf = 0 immediately, no done afterwards.
  - Then start A=0101, B=0011, Sub=1 -> Out=0010, Cout=1, Ovf=0.
- Add, WIDTH=4, one operation per start:
  - 1000+0001 -> 1001, Cout=0, Ovf=0.
  - 1011+1010 -> 0101, Cout=1, Ovf=1.
  - 1111+1001 -> 1000, Cout=1, Ovf=0.
  - 0111+0001 -> 1000, Cout=0, Ovf=1.
- Carry-in and subtract, WIDTH=4:
  - 0110+0011 with Cin=1 -> 1010, Cout=0, Ovf=1.
  - 0011-0101 with Sub=1, Cin=1 -> 1110, Cout=0, Ovf=0 (Cin ignored).
- Timing:
  - Required: done high for exactly 1 cycle, exactly 4 edges after the start edge.
  - Required: busy high for 4 cycles.
  - Change A/B during RUN -> result unaffected.
- start while busy:
  - Pulse start at cycle 2 of RUN with different operands.
  - Required: ignored; only one done; Out reflects the first operands.
- WIDTH=8 instance:
  - 0xFF+0x01 -> Out=0x00, Cout=1, Ovf=0, done 8 edges after start.
  - 0x80-0x01 -> Out=0x7F, Cout=1, Ovf=1.

Source files
------------

// File: rtl/serial_add_sub.sv
// Bit-serial adder/subtractor: one full-adder cell plus a carry flop, LSB first.
// A start in IDLE latches the operands. RUN then takes WIDTH cycles, one bit per
// clock. DONE raises a one-cycle done pulse. Out/Cout/Ovf hold until the next
// operation completes.
module serial_add_sub #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             Sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Out,
  output logic             Cout,
  output logic             Ovf
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d, opb_q, opb_d, res_q, res_d, out_q, out_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
  logic             sum, cnext, last;

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // datapath registers: operand/result shifters, carry, bit counter, results
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      out_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      out_q   <= out_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  // next-state and datapath next values; subtract is A + ~B + 1 via the carry seed
  always_comb begin
    sum     = opa_q[0] ^ opb_q[0] ^ carry_q;
    cnext   = (opa_q[0] & opb_q[0]) | (opa_q[0] & carry_q) | (opb_q[0] & carry_q);
    last    = (cnt_q == CW'(WIDTH-1));
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    out_d   = out_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          opa_d   = A;
          opb_d   = Sub ? ~B : B;
          carry_d = Sub ? 1'b1 : Cin;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        res_d   = {sum, res_q[WIDTH-1:1]};
        opa_d   = opa_q >> 1;
        opb_d   = opb_q >> 1;
        carry_d = cnext;
        cnt_d   = cnt_q + CW'(1);
        if (last) begin
          // carry_q here is the carry into the MSB, cnext the carry out of it
          out_d   = {sum, res_q[WIDTH-1:1]};
          cout_d  = cnext;
          ovf_d   = carry_q ^ cnext;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);
  assign Out  = out_q;
  assign Cout = cout_q;
  assign Ovf  = ovf_q;
endmodule

// File: tb/tb_serial_add_sub.sv
// Scoreboard bench for serial_add_sub. It runs a WIDTH=4 and a WIDTH=8 instance.
// Expected results are queued when an operation is launched. They are popped
// when done is seen.
module tb_serial_add_sub;
  logic clk, rst;
  logic st4, sub4, cin4, busy4, done4, cout4, ovf4;
  logic [3:0] a4, b4, out4;
  logic st8, sub8, cin8, busy8, done8, cout8, ovf8;
  logic [7:0] a8, b8, out8;

  int n_cmp, n_bad;
  logic [33:0] q4[$];
  logic [33:0] q8[$];
  logic [33:0] prev4, prev8, e4, e8;

  serial_add_sub #(.WIDTH(4)) u4 (
    .clk(clk), .rst(rst), .start(st4), .Sub(sub4), .A(a4), .B(b4), .Cin(cin4),
    .busy(busy4), .done(done4), .Out(out4), .Cout(cout4), .Ovf(ovf4));

  serial_add_sub #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start(st8), .Sub(sub8), .A(a8), .B(b8), .Cin(cin8),
    .busy(busy8), .done(done8), .Out(out8), .Cout(cout8), .Ovf(ovf8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // reference: {ovf, cout, out[31:0]}; overflow from operand/result signs
  function automatic logic [33:0] model(input int w, input logic [31:0] a, input logic [31:0] b,
                                        input logic sub, input logic cin);
    logic [31:0] mask, aa, bb, o;
    logic [63:0] full;
    logic co, ov;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    aa   = a & mask;
    bb   = sub ? (~b & mask) : (b & mask);
    full = {32'd0, aa} + {32'd0, bb} + {63'd0, (sub | cin)};
    o    = full[31:0] & mask;
    co   = full[w];
    ov   = (aa[w-1] == bb[w-1]) && (o[w-1] != aa[w-1]);
    return {ov, co, o};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // launch one op; optionally scramble inputs during RUN or re-pulse start at RUN cycle 2
  task automatic op(input bit w8, input logic [7:0] a, input logic [7:0] b,
                    input logic sub, input logic cin, input bit scramble, input bit restart);
    int n, nb;
    bit seen;
    if (w8) begin
      st8 = 1; a8 = a; b8 = b; sub8 = sub; cin8 = cin;
      q8.push_back(model(8, {24'd0, a}, {24'd0, b}, sub, cin));
    end else begin
      st4 = 1; a4 = a[3:0]; b4 = b[3:0]; sub4 = sub; cin4 = cin;
      q4.push_back(model(4, {28'd0, a[3:0]}, {28'd0, b[3:0]}, sub, cin));
    end
    cyc();
    st4 = 0; st8 = 0;
    n = 0; nb = 0; seen = 0;
    while (!seen && n < 40) begin
      if (w8 ? busy8 : busy4) nb++;
      if (scramble) begin
        a4 = 4'($urandom); b4 = 4'($urandom); sub4 = 1'($urandom); cin4 = 1'($urandom);
        a8 = 8'($urandom); b8 = 8'($urandom); sub8 = 1'($urandom); cin8 = 1'($urandom);
      end
      if (restart && n == 2) begin
        if (w8) begin st8 = 1; a8 = ~a; b8 = a; end
        else begin st4 = 1; a4 = ~a[3:0]; b4 = a[3:0]; end
      end else begin
        st4 = 0; st8 = 0;
      end
      cyc();
      n++;
      seen = w8 ? done8 : done4;
    end
    st4 = 0; st8 = 0;
    chk(w8 ? "lat8" : "lat4", n, w8 ? 8 : 4);
    chk(w8 ? "busy8" : "busy4", nb, w8 ? 8 : 4);
    cyc();
    chk(w8 ? "pulse8" : "pulse4", w8 ? done8 : done4, 0);
  endtask

  // output monitors: results only change together with done, and match the scoreboard
  always @(negedge clk) begin
    if (rst) prev4 = {ovf4, cout4, 28'd0, out4};
    else begin
      if ({ovf4, cout4, 28'd0, out4} != prev4) chk("hold4", done4, 1);
      if (done4) begin
        chk("sb4_nonempty", q4.size() != 0, 1);
        if (q4.size() != 0) begin
          e4 = q4.pop_front();
          chk("out4", out4, e4[31:0]);
          chk("cout4", cout4, e4[32]);
          chk("ovf4", ovf4, e4[33]);
        end
      end
      prev4 = {ovf4, cout4, 28'd0, out4};
    end
  end

  always @(negedge clk) begin
    if (rst) prev8 = {ovf8, cout8, 24'd0, out8};
    else begin
      if ({ovf8, cout8, 24'd0, out8} != prev8) chk("hold8", done8, 1);
      if (done8) begin
        chk("sb8_nonempty", q8.size() != 0, 1);
        if (q8.size() != 0) begin
          e8 = q8.pop_front();
          chk("out8", out8, e8[31:0]);
          chk("cout8", cout8, e8[32]);
          chk("ovf8", ovf8, e8[33]);
        end
      end
      prev8 = {ovf8, cout8, 24'd0, out8};
    end
  end

  initial begin
    n_cmp = 0; n_bad = 0;
    rst = 1;
    st4 = 0; sub4 = 0; cin4 = 0; a4 = '0; b4 = '0;
    st8 = 0; sub8 = 0; cin8 = 0; a8 = '0; b8 = '0;
    cyc(); cyc();
    chk("rst_busy4", busy4, 0); chk("rst_done4", done4, 0);
    chk("rst_out4", out4, 0);   chk("rst_cout4", cout4, 0); chk("rst_ovf4", ovf4, 0);
    chk("rst_busy8", busy8, 0); chk("rst_out8", out8, 0);
    rst = 0;
    cyc();

    // add vectors
    op(0, 8'h8, 8'h1, 0, 0, 0, 0);
    op(0, 8'hB, 8'hA, 0, 0, 0, 0);
    op(0, 8'hF, 8'h9, 0, 0, 0, 0);
    op(0, 8'h7, 8'h1, 0, 0, 0, 0);
    // carry-in, subtract with Cin ignored, inputs scrambled during RUN
    op(0, 8'h6, 8'h3, 0, 1, 0, 0);
    op(0, 8'h3, 8'h5, 1, 1, 1, 0);
    // start during RUN is ignored
    op(0, 8'h2, 8'h9, 0, 0, 0, 1);
    repeat (6) cyc();
    chk("no_relaunch", busy4, 0);

    // leave nonzero results, then abort an op with reset
    op(0, 8'hB, 8'hA, 0, 0, 0, 0);
    st4 = 1; a4 = 4'h7; b4 = 4'h7; sub4 = 0; cin4 = 0;
    cyc();
    st4 = 0;
    cyc(); cyc();
    rst = 1;
    #1;
    chk("abort_busy", busy4, 0); chk("abort_done", done4, 0);
    chk("abort_out", out4, 0);   chk("abort_cout", cout4, 0); chk("abort_ovf", ovf4, 0);
    cyc();
    rst = 0;
    repeat (8) cyc();
    chk("abort_quiet_out", out4, 0);
    chk("abort_quiet_busy", busy4, 0);
    op(0, 8'h5, 8'h3, 1, 0, 0, 0);

    // WIDTH=8 instance
    op(1, 8'hFF, 8'h01, 0, 0, 0, 0);
    op(1, 8'h80, 8'h01, 1, 0, 0, 0);
    op(1, 8'h7F, 8'h7F, 0, 1, 1, 1);

    // random mix on both instances
    for (int i = 0; i < 8; i++) begin
      op(0, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 0);
      op(1, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 0);
    end

    repeat (3) cyc();
    chk("sb4_drained", q4.size(), 0);
    chk("sb8_drained", q8.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
